// File: rtl/noc_flit_pkg.sv
// Flit format shared by the butterfly injectors, switches and benches.
// A flit is {type[1:0], body[15:0]}; an all-zero flit is NULL and terminates a packet.
package noc_flit_pkg;

  localparam int FLIT_W = 18;

  localparam logic [1:0] TYPE_HDR  = 2'b11;
  localparam logic [1:0] TYPE_PCK  = 2'b10;
  localparam logic [1:0] TYPE_NULL = 2'b00;

  typedef logic [FLIT_W-1:0] flit_t;

  localparam flit_t NULL_FLIT = '0;

  // Header body carries the route bits left-aligned; dest must arrive zero-extended.
  function automatic flit_t make_header(input logic [15:0] dest, input int dest_w);
    logic [15:0] body;
    body = dest << (16 - dest_w);
    return {TYPE_HDR, body};
  endfunction

  function automatic flit_t make_payload(input logic [15:0] word);
    return {TYPE_PCK, word};
  endfunction

endpackage

// File: rtl/flit_injector.sv
// Source end of a butterfly flit channel: turns a dest + word stream into
// HEADER, PAYLOAD... flits followed by a guaranteed run of NULL flits.
// Long messages are fragmented at MAX_WORDS; a stall mid-packet cuts the packet
// and the remainder is re-sent under a new header to the same destination.
module flit_injector
  import noc_flit_pkg::*;
#(
  parameter int DEST_W    = 2,
  parameter int MAX_WORDS = 8,
  parameter int MIN_GAP   = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [DEST_W-1:0] msg_dest,
  input  logic [15:0]       msg_data,
  input  logic              msg_last,
  output logic [FLIT_W-1:0] out_flit,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int GC_W = $clog2(MIN_GAP + 1);

  // Counter values at which the current word / gap flit is the final one.
  localparam logic [WC_W-1:0] WLAST = WC_W'(MAX_WORDS - 1);
  localparam logic [GC_W-1:0] GLAST = GC_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_GAP
  } state_t;

  state_t            state, state_n;
  logic              frag, frag_n;
  logic [DEST_W-1:0] dest_q, dest_n;
  logic [WC_W-1:0]   wcnt, wcnt_n;
  logic [GC_W-1:0]   gcnt, gcnt_n;
  flit_t             flit_n;
  logic              pkt_inc, und_inc;

  // Words are only accepted while a packet body is open.
  assign msg_ready = (state == ST_BODY);

  // Next-state and next-flit decode for the packet sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_n = state;
    frag_n  = frag;
    dest_n  = dest_q;
    wcnt_n  = wcnt;
    gcnt_n  = gcnt;
    flit_n  = NULL_FLIT;
    pkt_inc = 1'b0;
    und_inc = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // The header costs a cycle of its own; no word is consumed here.
        if (msg_valid) begin
          flit_n  = make_header(16'(frag ? dest_q : msg_dest), DEST_W);
          if (!frag) dest_n = msg_dest;
          wcnt_n  = '0;
          pkt_inc = 1'b1;
          state_n = ST_BODY;
        end
      end

      ST_BODY: begin
        if (msg_valid) begin
          flit_n = make_payload(msg_data);
          wcnt_n = wcnt + 1'b1;
          if (msg_last) begin
            frag_n  = 1'b0;
            gcnt_n  = '0;
            state_n = ST_GAP;
          end else if (wcnt == WLAST) begin
            frag_n  = 1'b1;
            gcnt_n  = '0;
            state_n = ST_GAP;
          end
        end else begin
          // The NULL emitted for the stall is already the first gap flit, so with a
          // single-flit gap the next header may follow straight away.
          und_inc = 1'b1;
          frag_n  = 1'b1;
          gcnt_n  = GC_W'(1);
          state_n = (MIN_GAP == 1) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gcnt == GLAST) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Register state, flit, status and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      frag         <= 1'b0;
      dest_q       <= '0;
      wcnt         <= '0;
      gcnt         <= '0;
      out_flit     <= NULL_FLIT;
      busy         <= 1'b0;
      pkt_cnt      <= '0;
      underrun_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      frag     <= frag_n;
      dest_q   <= dest_n;
      wcnt     <= wcnt_n;
      gcnt     <= gcnt_n;
      out_flit <= flit_n;
      busy     <= (state_n != ST_IDLE) || frag_n;
      if (pkt_inc && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + 1'b1;
      if (und_inc && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: three differently parameterised instances share one
// input stream; each is compared every cycle against a packet-level model, and
// the directed scenarios are also checked against literal flit sequences.
module tb_flit_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic [15:0] msg_dest;
  logic [15:0] msg_data;
  logic        msg_last;

  logic        ready_a, busy_a, ready_b, busy_b, ready_c, busy_c;
  logic [17:0] flit_a, flit_b, flit_c;
  logic [15:0] pkt_a, und_a, pkt_c, und_c;
  logic [2:0]  pkt_b, und_b;

  always #5 clk = ~clk;

  // a: defaults; b: short packets and narrow counters; c: wide dest, long gap.
  flit_injector #(.DEST_W(2), .MAX_WORDS(8), .MIN_GAP(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(ready_a),
    .msg_dest(msg_dest[1:0]), .msg_data(msg_data), .msg_last(msg_last),
    .out_flit(flit_a), .busy(busy_a), .pkt_cnt(pkt_a), .underrun_cnt(und_a));

  flit_injector #(.DEST_W(2), .MAX_WORDS(2), .MIN_GAP(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(ready_b),
    .msg_dest(msg_dest[1:0]), .msg_data(msg_data), .msg_last(msg_last),
    .out_flit(flit_b), .busy(busy_b), .pkt_cnt(pkt_b), .underrun_cnt(und_b));

  flit_injector #(.DEST_W(4), .MAX_WORDS(3), .MIN_GAP(3), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(ready_c),
    .msg_dest(msg_dest[3:0]), .msg_data(msg_data), .msg_last(msg_last),
    .out_flit(flit_c), .busy(busy_c), .pkt_cnt(pkt_c), .underrun_cnt(und_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet-level reference: words < 0 means no packet is open; owed counts the
  // NULL flits still due before another header may go out; resume means the
  // next header continues a cut or fragmented message.
  typedef struct {
    int          words;
    int          owed;
    bit          resume;
    int          saved;
    int          pkts;
    int          unds;
    logic [17:0] flit;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.words = -1; m.owed = 0; m.resume = 1'b0; m.saved = 0;
    m.pkts = 0; m.unds = 0; m.flit = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int dest_w, input int max_w,
                                    input int min_gap, input int cnt_max, input bit v,
                                    input int data, input bit last, input int dest);
    int d;
    d = dest % (1 << dest_w);
    if (m.words < 0) begin
      if (m.owed > 0) begin
        m.flit = '0;
        m.owed--;
      end else if (v) begin
        if (!m.resume) m.saved = d;
        m.flit  = {2'b11, 16'(m.saved << (16 - dest_w))};
        m.words = 0;
        if (m.pkts < cnt_max) m.pkts++;
      end else begin
        m.flit = '0;
      end
    end else if (v) begin
      m.flit = {2'b10, 16'(data)};
      m.words++;
      if (last) begin
        m.words = -1; m.resume = 1'b0; m.owed = min_gap;
      end else if (m.words == max_w) begin
        m.words = -1; m.resume = 1'b1; m.owed = min_gap;
      end
    end else begin
      m.flit = '0;
      if (m.unds < cnt_max) m.unds++;
      m.words = -1; m.resume = 1'b1; m.owed = min_gap - 1;
    end
    return m;
  endfunction

  task automatic compare_one(input string nm, input mdl_t m, input logic [17:0] flit,
                             input logic rdy, input logic bsy, input logic [31:0] pc,
                             input logic [31:0] uc);
    check({nm, "_flit"}, 32'(flit), 32'(m.flit));
    check({nm, "_ready"}, 32'(rdy), 32'(m.words >= 0));
    check({nm, "_busy"}, 32'(bsy), 32'((m.words >= 0) || (m.owed > 0) || m.resume));
    check({nm, "_pkt_cnt"}, pc, 32'(m.pkts));
    check({nm, "_underrun_cnt"}, uc, 32'(m.unds));
  endtask

  // Advance one clock: models follow the edge, DUTs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
    end else begin
      ma = mdl_step(ma, 2, 8, 1, 65535, msg_valid, msg_data, msg_last, msg_dest);
      mb = mdl_step(mb, 2, 2, 1, 7, msg_valid, msg_data, msg_last, msg_dest);
      mc = mdl_step(mc, 4, 3, 3, 65535, msg_valid, msg_data, msg_last, msg_dest);
    end
    #1;
    compare_one("a", ma, flit_a, ready_a, busy_a, 32'(pkt_a), 32'(und_a));
    compare_one("b", mb, flit_b, ready_b, busy_b, 32'(pkt_b), 32'(und_b));
    compare_one("c", mc, flit_c, ready_c, busy_c, 32'(pkt_c), 32'(und_c));
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit l, input logic [15:0] dst);
    msg_valid = v; msg_data = d; msg_last = l; msg_dest = dst;
    tick();
  endtask

  task automatic do_reset();
    msg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_dest = '0;
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();

    // 1: quiet after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 16'h0);
      check("t1_idle_flit", 32'(flit_a), 32'h0);
      check("t1_idle_ready", 32'(ready_a), 32'h0);
    end

    // 2: two-word message to dest 00
    do_reset();
    drive(1'b1, 16'hDEAD, 1'b0, 16'h0); check("t2_hdr", 32'(flit_a), 32'h30000);
    drive(1'b1, 16'hDEAD, 1'b0, 16'h0); check("t2_w0", 32'(flit_a), 32'h2DEAD);
    drive(1'b1, 16'hBEEF, 1'b1, 16'h0); check("t2_w1", 32'(flit_a), 32'h2BEEF);
    drive(1'b0, 16'h0, 1'b0, 16'h0);    check("t2_null", 32'(flit_a), 32'h0);
    check("t2_pkt_cnt", 32'(pkt_a), 32'd1);
    check("t2_busy", 32'(busy_a), 32'd0);

    // 3: back-to-back single-word messages
    do_reset();
    drive(1'b1, 16'hCA7E, 1'b1, 16'h1); check("t3_hdr0", 32'(flit_a), 32'h34000);
    drive(1'b1, 16'hCA7E, 1'b1, 16'h1); check("t3_w0", 32'(flit_a), 32'h2CA7E);
    drive(1'b1, 16'hF00D, 1'b1, 16'h3); check("t3_gap", 32'(flit_a), 32'h0);
    drive(1'b1, 16'hF00D, 1'b1, 16'h3); check("t3_hdr1", 32'(flit_a), 32'h3C000);
    drive(1'b1, 16'hF00D, 1'b1, 16'h3); check("t3_w1", 32'(flit_a), 32'h2F00D);
    drive(1'b0, 16'h0, 1'b0, 16'h3);    check("t3_null", 32'(flit_a), 32'h0);

    // 4: fragmentation on the MAX_WORDS=2 instance
    do_reset();
    drive(1'b1, 16'h1111, 1'b0, 16'h2); check("t4_hdr0", 32'(flit_b), 32'h38000);
    drive(1'b1, 16'h1111, 1'b0, 16'h2); check("t4_w0", 32'(flit_b), 32'h21111);
    drive(1'b1, 16'h2222, 1'b0, 16'h2); check("t4_w1", 32'(flit_b), 32'h22222);
    drive(1'b1, 16'h3333, 1'b1, 16'h0); check("t4_gap", 32'(flit_b), 32'h0);
    drive(1'b1, 16'h3333, 1'b1, 16'h0); check("t4_hdr1", 32'(flit_b), 32'h38000);
    drive(1'b1, 16'h3333, 1'b1, 16'h0); check("t4_w2", 32'(flit_b), 32'h23333);
    drive(1'b0, 16'h0, 1'b0, 16'h0);    check("t4_null", 32'(flit_b), 32'h0);
    check("t4_pkt_cnt", 32'(pkt_b), 32'd2);

    // 5: one-cycle stall after the first word; the re-header ignores the new dest
    do_reset();
    drive(1'b1, 16'hAAAA, 1'b0, 16'h2); check("t5_hdr0", 32'(flit_a), 32'h38000);
    drive(1'b1, 16'hAAAA, 1'b0, 16'h2); check("t5_w0", 32'(flit_a), 32'h2AAAA);
    drive(1'b0, 16'h0, 1'b0, 16'h2);    check("t5_cut", 32'(flit_a), 32'h0);
    drive(1'b1, 16'hBBBB, 1'b1, 16'h1); check("t5_hdr1", 32'(flit_a), 32'h38000);
    drive(1'b1, 16'hBBBB, 1'b1, 16'h1); check("t5_w1", 32'(flit_a), 32'h2BBBB);
    drive(1'b0, 16'h0, 1'b0, 16'h1);    check("t5_null", 32'(flit_a), 32'h0);
    check("t5_underrun_cnt", 32'(und_a), 32'd1);
    check("t5_pkt_cnt", 32'(pkt_a), 32'd2);

    // 6: asynchronous reset while in BODY
    do_reset();
    drive(1'b1, 16'h1234, 1'b0, 16'h3); check("t6_hdr", 32'(flit_a), 32'h3C000);
    drive(1'b1, 16'h1234, 1'b0, 16'h3); check("t6_w0", 32'(flit_a), 32'h21234);
    #2 rst = 1'b1;
    #1;
    check("t6_async_flit", 32'(flit_a), 32'h0);
    check("t6_async_busy", 32'(busy_a), 32'h0);
    check("t6_async_ready", 32'(ready_a), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h1);    check("t6_no_rehdr", 32'(flit_a), 32'h0);
    drive(1'b1, 16'h5678, 1'b1, 16'h1); check("t6_new_hdr", 32'(flit_a), 32'h34000);

    // Randomised traffic with occasional resets; the models check every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 3) == 0,
              16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
